// File: rtl/mining_pkg.sv
// Shared types and defaults for the mining datapath control blocks.
package mining_pkg;

  localparam int NONCE_W_DEF = 32;
  localparam int HASH_W_DEF  = 256;

  localparam logic [NONCE_W_DEF-1:0] NONCE_ALL_ONES = '1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_FOUND = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/hash_lt_cmp.sv
// Wide unsigned less-than built from fixed-size chunks, so the chunk results
// can later be registered without changing the combine step.
module hash_lt_cmp #(
  parameter int W  = 256,
  parameter int CW = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         lt
);

  localparam int NCH = (W + CW - 1) / CW;
  localparam int PW  = NCH * CW;

  logic [PW-1:0]  a_pad;
  logic [PW-1:0]  b_pad;
  logic [NCH-1:0] ch_lt;
  logic [NCH-1:0] ch_eq;

  assign a_pad = PW'(a);
  assign b_pad = PW'(b);

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_chunk
      assign ch_lt[gi] = a_pad[gi*CW +: CW] <  b_pad[gi*CW +: CW];
      assign ch_eq[gi] = a_pad[gi*CW +: CW] == b_pad[gi*CW +: CW];
    end
  endgenerate

  // Walk from the least significant chunk up: a higher chunk decides unless equal.
  always_comb begin
    lt = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      lt = ch_lt[i] | (ch_eq[i] & lt);
    end
  end

endmodule

// File: rtl/nonce_search_ctrl.sv
// Sweeps a nonce range through the external hash core and reports the first
// nonce whose hash is below the target, or that the range was exhausted.
module nonce_search_ctrl
  import mining_pkg::*;
#(
  parameter int NONCE_W = NONCE_W_DEF,
  parameter int HASH_W  = HASH_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [NONCE_W-1:0] nonce_start,
  input  logic [NONCE_W-1:0] nonce_limit,
  input  logic [HASH_W-1:0]  target,
  output logic               hash_req,
  output logic [NONCE_W-1:0] hash_nonce,
  input  logic               hash_ack,
  input  logic [HASH_W-1:0]  hash_in,
  output logic               valid,
  output logic [NONCE_W-1:0] nonce,
  output logic               busy,
  output logic               exhausted
);

  state_t state_reg, state_next;

  logic [NONCE_W-1:0] cur_reg, cur_next;
  logic [NONCE_W-1:0] limit_reg, limit_next;
  logic [HASH_W-1:0]  target_reg, target_next;
  logic [HASH_W-1:0]  hash_reg, hash_next;

  logic               hash_req_reg, hash_req_next;
  logic [NONCE_W-1:0] hash_nonce_reg, hash_nonce_next;
  logic               valid_reg, valid_next;
  logic [NONCE_W-1:0] nonce_reg, nonce_next;
  logic               busy_reg, busy_next;
  logic               exhausted_reg, exhausted_next;

  logic hit;

  hash_lt_cmp #(
    .W (HASH_W)
  ) u_cmp (
    .a  (hash_reg),
    .b  (target_reg),
    .lt (hit)
  );

  always_comb begin
    state_next  = state_reg;
    cur_next    = cur_reg;
    limit_next  = limit_reg;
    target_next = target_reg;
    hash_next   = hash_reg;

    case (state_reg)
      ST_IDLE: begin
        if (start && !abort) begin
          cur_next    = nonce_start;
          limit_next  = nonce_limit;
          target_next = target;
          state_next  = ST_ISSUE;
        end
      end
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT: begin
        if (hash_ack && !abort) begin
          hash_next  = hash_in;
          state_next = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (hit) begin
          state_next = ST_FOUND;
        end else if (cur_reg == limit_reg) begin
          state_next = ST_DONE;
        end else begin
          cur_next   = cur_reg + NONCE_W'(1);
          state_next = ST_ISSUE;
        end
      end
      ST_FOUND: state_next = ST_IDLE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase

    // Abort overrides any transition, including a result arriving this cycle.
    if (abort && state_reg != ST_IDLE) begin
      state_next = ST_IDLE;
    end
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_comb begin
    hash_req_next   = (state_next == ST_ISSUE);
    hash_nonce_next = (state_next == ST_ISSUE) ? cur_next : hash_nonce_reg;
    valid_next      = (state_next == ST_FOUND);
    nonce_next      = (state_next == ST_FOUND) ? cur_next : '0;
    busy_next       = (state_next != ST_IDLE);
    exhausted_next  = (state_next == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      cur_reg        <= '0;
      limit_reg      <= '0;
      target_reg     <= '0;
      hash_reg       <= '0;
      hash_req_reg   <= 1'b0;
      hash_nonce_reg <= '0;
      valid_reg      <= 1'b0;
      nonce_reg      <= '0;
      busy_reg       <= 1'b0;
      exhausted_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cur_reg        <= cur_next;
      limit_reg      <= limit_next;
      target_reg     <= target_next;
      hash_reg       <= hash_next;
      hash_req_reg   <= hash_req_next;
      hash_nonce_reg <= hash_nonce_next;
      valid_reg      <= valid_next;
      nonce_reg      <= nonce_next;
      busy_reg       <= busy_next;
      exhausted_reg  <= exhausted_next;
    end
  end

  assign hash_req   = hash_req_reg;
  assign hash_nonce = hash_nonce_reg;
  assign valid      = valid_reg;
  assign nonce      = nonce_reg;
  assign busy       = busy_reg;
  assign exhausted  = exhausted_reg;

endmodule

// File: tb/tb_nonce_search_ctrl.sv
// Scoreboard bench for nonce_search_ctrl: expected requests and results are
// queued when a search is launched and popped as the controller produces them.
module tb_nonce_search_ctrl;
  import mining_pkg::*;

  localparam int NW = NONCE_W_DEF;
  localparam int HW = HASH_W_DEF;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [NW-1:0] nonce_start = '0;
  logic [NW-1:0] nonce_limit = '0;
  logic [HW-1:0] target = '0;
  logic          hash_ack = 1'b0;
  logic [HW-1:0] hash_in = '0;
  logic          hash_req;
  logic [NW-1:0] hash_nonce;
  logic          valid;
  logic [NW-1:0] nonce;
  logic          busy;
  logic          exhausted;

  nonce_search_ctrl #(.NONCE_W(NW), .HASH_W(HW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .nonce_start (nonce_start),
    .nonce_limit (nonce_limit),
    .target      (target),
    .hash_req    (hash_req),
    .hash_nonce  (hash_nonce),
    .hash_ack    (hash_ack),
    .hash_in     (hash_in),
    .valid       (valid),
    .nonce       (nonce),
    .busy        (busy),
    .exhausted   (exhausted)
  );

  always #5 clk = ~clk;

  // kind is {valid, exhausted} as expected on the output pins
  typedef struct {
    logic [1:0]    kind;
    logic [NW-1:0] nonce;
  } res_t;

  logic [NW-1:0] req_q[$];
  res_t          res_q[$];
  res_t          mon_e;
  int            n_cmp = 0;
  int            n_err = 0;

  localparam logic [HW-1:0] T1 = {64'h0000_0000_FFFF_0000, 192'h0} + HW'(32'h1234);
  localparam logic [HW-1:0] T2 = {4'h0, {(HW-4){1'b1}}};
  localparam logic [HW-1:0] T3 = {1'b1, {(HW-1){1'b0}}};

  task automatic check_val(input string tag, input logic [HW-1:0] got, input logic [HW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [HW-1:0] hash_for(input logic [NW-1:0] n, input logic [HW-1:0] tgt,
                                             input bit hit_en, input logic [NW-1:0] hit_n);
    if (hit_en && n == hit_n) return tgt - HW'(1);
    if (tgt == '0) return {$urandom(), $urandom(), $urandom(), $urandom(),
                           $urandom(), $urandom(), $urandom(), $urandom()};
    // Never below the target; equal to it whenever the low nibble is zero.
    return tgt | (HW'(n[3:0]) << 200);
  endfunction

  // Monitor: every request and every result pulse must match the head of its queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (hash_req) begin
        check_val("req_pending", HW'(req_q.size() != 0), HW'(1));
        if (req_q.size() != 0) check_val("hash_nonce", HW'(hash_nonce), HW'(req_q.pop_front()));
      end
      if (valid || exhausted) begin
        check_val("res_pending", HW'(res_q.size() != 0), HW'(1));
        if (res_q.size() != 0) begin
          mon_e = res_q.pop_front();
          check_val("res_kind", HW'({valid, exhausted}), HW'(mon_e.kind));
          check_val("res_nonce", HW'(nonce), HW'(mon_e.nonce));
        end
      end
    end
  end

  // Called on a negedge while the controller is IDLE; returns on its first IDLE negedge.
  task automatic run_search(input logic [NW-1:0] ns, input logic [NW-1:0] nl, input logic [HW-1:0] tgt,
                            input bit hit_en, input logic [NW-1:0] hit_n, input int lat, input bit poke);
    logic [NW-1:0] n = ns;
    logic [NW-1:0] cur_n;
    int            nreq = 0;
    int            w;
    for (int k = 0; k < 64; k++) begin
      req_q.push_back(n);
      nreq++;
      if (hit_en && n == hit_n) begin
        res_q.push_back('{kind: 2'b10, nonce: n});
        break;
      end
      if (n == nl) begin
        res_q.push_back('{kind: 2'b01, nonce: '0});
        break;
      end
      n = n + NW'(1);
    end
    $display("txn search start=%08h limit=%08h hit=%0d at=%08h lat=%0d reqs=%0d", ns, nl, hit_en, hit_n, lat, nreq);

    nonce_start = ns;
    nonce_limit = nl;
    target      = tgt;
    start       = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    nonce_start = '0;
    nonce_limit = '0;
    target      = '0;

    for (int k = 0; k < nreq; k++) begin
      w = 0;
      while (!hash_req && w < 50) begin
        @(negedge clk);
        w++;
      end
      check_val("req_seen", HW'(hash_req), HW'(1));
      if (!hash_req) return;
      cur_n = hash_nonce;
      for (int d = 0; d < lat; d++) begin
        @(negedge clk);
        if (poke && k == 0 && d == 0) begin
          start       = 1'b1;
          nonce_start = ~ns;
          nonce_limit = ~ns;
        end else begin
          start = 1'b0;
        end
      end
      hash_in  = hash_for(cur_n, tgt, hit_en, hit_n);
      hash_ack = 1'b1;
      @(negedge clk);
      hash_ack    = 1'b0;
      start       = 1'b0;
      nonce_start = '0;
      nonce_limit = '0;
      hash_in     = {$urandom(), $urandom(), $urandom(), $urandom(),
                     $urandom(), $urandom(), $urandom(), $urandom()};
    end

    w = 0;
    while (busy && w < 20) begin
      @(negedge clk);
      w++;
    end
    check_val("busy_low", HW'(busy), '0);
    check_val("idle_valid", HW'(valid), '0);
    check_val("idle_nonce", HW'(nonce), '0);
    check_val("req_q_drained", HW'(req_q.size()), '0);
    check_val("res_q_drained", HW'(res_q.size()), '0);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_busy"}, HW'(busy), '0);
    check_val({tag, "_hash_req"}, HW'(hash_req), '0);
    check_val({tag, "_hash_nonce"}, HW'(hash_nonce), '0);
    check_val({tag, "_valid"}, HW'(valid), '0);
    check_val({tag, "_nonce"}, HW'(nonce), '0);
    check_val({tag, "_exhausted"}, HW'(exhausted), '0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("post_reset");

    run_search(NW'(32'h10), NW'(32'h20), T1, 1'b1, NW'(32'h13), 2, 1'b0);
    run_search(NW'(32'h5), NW'(32'h7), '0, 1'b0, '0, 1, 1'b0);
    run_search(NONCE_ALL_ONES - NW'(1), NW'(32'h1), T2, 1'b0, '0, 3, 1'b0);
    run_search(NW'(32'h30), NW'(32'h33), T1, 1'b1, NW'(32'h32), 3, 1'b1);
    run_search(NW'(32'h77), NW'(32'h77), T1, 1'b0, '0, 1, 1'b0);
    run_search(NW'(32'h8), NW'(32'hA), T3, 1'b1, NW'(32'hA), 1, 1'b0);

    // Abort colliding with a hitting ack in WAIT
    $display("txn abort collision");
    req_q.push_back(NW'(32'h40));
    nonce_start = NW'(32'h40);
    nonce_limit = NW'(32'h50);
    target      = T1;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    hash_in  = T1 - HW'(1);
    hash_ack = 1'b1;
    abort    = 1'b1;
    @(negedge clk);
    hash_ack = 1'b0;
    abort    = 1'b0;
    check_val("abort_busy", HW'(busy), '0);
    check_val("abort_valid", HW'(valid), '0);
    check_val("abort_req", HW'(hash_req), '0);
    repeat (6) @(negedge clk);
    check_val("abort_still_idle", HW'(busy), '0);
    check_val("abort_req_q", HW'(req_q.size()), '0);

    // Abort held in IDLE blocks a start
    $display("txn start blocked by abort");
    start = 1'b1;
    abort = 1'b1;
    nonce_start = NW'(32'h60);
    nonce_limit = NW'(32'h60);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check_val("blocked_busy", HW'(busy), '0);
    @(negedge clk);
    check_val("blocked_req", HW'(hash_req), '0);

    // Spurious ack while IDLE
    $display("txn spurious ack in idle");
    hash_in  = '0;
    hash_ack = 1'b1;
    @(negedge clk);
    hash_ack = 1'b0;
    @(negedge clk);
    check_val("spur_busy", HW'(busy), '0);
    check_val("spur_valid", HW'(valid), '0);
    check_val("spur_exhausted", HW'(exhausted), '0);

    // Reset while waiting for the hash core
    $display("txn reset mid-wait");
    req_q.push_back(NW'(32'h100));
    nonce_start = NW'(32'h100);
    nonce_limit = NW'(32'h200);
    target      = T1;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check_val("pre_reset_busy", HW'(busy), HW'(1));
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("mid_reset");
    reset = 1'b0;
    @(negedge clk);
    check_val("after_reset_busy", HW'(busy), '0);
    run_search('0, '0, T1, 1'b1, '0, 2, 1'b0);

    repeat (3) @(negedge clk);
    check_val("final_req_q", HW'(req_q.size()), '0);
    check_val("final_res_q", HW'(res_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nonce_search_ctrl.md
Name: nonce_search_ctrl

Overview:
- Nonce-iteration controller for the mining datapath.
- Sweeps a nonce range and hands each nonce to the external hash core over a req/ack handshake.
- Compares each returned hash against the target.
- Emits a one-cycle valid+nonce on the first hit. This feeds the output-register stage directly downstream, which consumes exactly that valid/nonce pair.

Parameters:
NONCE_W, 32, nonce width
HASH_W, 256, hash and target width

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a search (honoured only in IDLE)
abort  in  1  level; cancels the search in progress
nonce_start  in  NONCE_W  first nonce, sampled on accepted start
nonce_limit  in  NONCE_W  last nonce (inclusive), sampled on accepted start
target  in  HASH_W  hit threshold, sampled on accepted start
hash_req  out  1  one-cycle request to the hash core
hash_nonce  out  NONCE_W  nonce under test; held stable from ISSUE until the ack
hash_ack  in  1  hash core result strobe
hash_in  in  HASH_W  hash result, valid when hash_ack=1
valid  out  1  one-cycle pulse: nonce is a hit (to the downstream stage)
nonce  out  NONCE_W  winning nonce when valid=1, else 0
busy  out  1  high in every state except IDLE
exhausted  out  1  one-cycle pulse: range swept with no hit

Behaviour:
- Reset (sync, high):
  - State = IDLE.
  - All outputs 0, including hash_nonce.
  - Internal cur, limit_q, target_q and hash_q = 0.
  - Reset mid-search discards all progress; no valid or exhausted is produced.
- States: IDLE, ISSUE, WAIT, CHECK, FOUND, DONE. All outputs are registered.
- IDLE: on start=1 (and abort=0), latch cur<=nonce_start, limit_q<=nonce_limit, target_q<=target, then go to ISSUE. start in any other state is ignored.
- ISSUE: hash_req=1 for exactly this cycle, with hash_nonce=cur. Then go to WAIT.
- WAIT:
  - On hash_ack=1: hash_q<=hash_in, then go to CHECK.
  - Otherwise remain in WAIT; there is no timeout.
  - hash_ack in any other state is ignored.
- CHECK: hit when hash_q < target_q (unsigned, full HASH_W).
  - Hit: go to FOUND.
  - No hit and cur==limit_q: go to DONE.
  - No hit otherwise: cur<=cur+1 modulo 2^NONCE_W, then go to ISSUE.
- FOUND: valid=1 and nonce=cur for one cycle, then IDLE.
- DONE: exhausted=1 for one cycle, then IDLE.
- Wrap-around:
  - If nonce_limit < nonce_start, the sweep passes through all-ones to 0 and continues up to the limit.
  - nonce_start==nonce_limit tests exactly one nonce.
- abort=1 in any non-IDLE state: next state IDLE, no valid, no exhausted, no further hash_req.
  - If abort and hash_ack arrive in the same cycle, abort wins and the result is dropped.
  - abort in IDLE blocks start.
- target_q==0 never hits, so a full sweep ends in DONE.
- Latency:
  - start to first hash_req: 1 cycle.
  - Per nonce: ISSUE(1) + WAIT(ack latency, minimum 1) + CHECK(1).
  - Hit to valid: 1 cycle after CHECK.
- After FOUND or DONE, a new start is accepted in the first IDLE cycle.

Decomposition:
- Shared package mining_pkg holds:
  - the state enum encoding (3-bit);
  - NONCE_W and HASH_W defaults;
  - NONCE_ALL_ONES.
- Optional sub-module hash_lt_cmp: HASH_W unsigned less-than, combinational, instantiated in CHECK. It is split out so it can later be pipelined without touching the FSM.

Test Plan:
- Single hit: start, range 0x10..0x20; hash core returns hit only for 0x13 → exactly 4 hash_req pulses (0x10-0x13), then valid=1 with nonce=0x00000013 for one cycle, then busy=0.
- Exhaust: range 0x5..0x7, target=0 → 3 hash_req pulses, then exhausted=1 for one cycle, valid never asserts, nonce stays 0.
- Wrap-around: nonce_start=0xFFFFFFFE, nonce_limit=0x00000001, no hits → hash_nonce sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001, then exhausted.
- Abort collision: abort and hash_ack asserted in the same WAIT cycle with a hitting hash → IDLE next cycle, valid=0, no further hash_req.
- Reset mid-WAIT: assert reset while busy → next cycle all outputs 0 and state IDLE; a later start with range 0x0..0x0 and a hit yields valid with nonce=0.
- Ignored inputs: start pulse during WAIT and spurious hash_ack during IDLE → no change in state or outputs.
